pci_target_fsm: RTL and testbench

- PCI target (responder) for the bus that the initiator controller drives.
- Claims memory read/write transactions that fall in its address window, asserts devsel/trdy/stop, and moves burst data to and from a small local word buffer.
- Sits beside the initiator state machine on the same shared frame/irdy/trdy/devsel bus.

---
 rtl/pci_pkg.sv | 20 ++
 rtl/pci_tgt_mem.sv | 38 +++
 rtl/pci_target_fsm.sv | 198 +++++++++++++++++++
 tb/tb_pci_target_fsm.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// pci_pkg: types and constants shared by the PCI initiator and target state
// machines.
//   pci_state_t   : 3-bit FSM state encoding, also used on the debug state ports
//   CMD_MEM_READ  : memory read command (address-phase cbe)
//   CMD_MEM_WRITE : memory write command (address-phase cbe)
package pci_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DECODE     = 3'd1,
        WAIT       = 3'd2,
        DATA       = 3'd3,
        DISCONNECT = 3'd4,
        TURNAROUND = 3'd5
    } pci_state_t;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

endpackage

// File: rtl/pci_tgt_mem.sv
// pci_tgt_mem: 2^ADDR_W x 32 local word buffer for the PCI target.
// The write port is clocked on the falling edge, matching the bus state updates,
// and has active-low byte enables. The read port is asynchronous.
// The contents are never reset.
//   clk     : bus clock, falling edge active
//   we      : write strobe
//   wr_addr : write word address
//   wr_data : write data
//   be_n    : active-low byte enables, bit i covers wr_data[8i+7:8i]
//   rd_addr : read word address
//   rd_data : read data, combinational from rd_addr
module pci_tgt_mem #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        be_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(negedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (!be_n[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pci_target_fsm.sv
// pci_target_fsm: PCI memory target. It claims memory read and memory write
// transactions inside a 2^ADDR_W-word window at BASE_ADDR and moves burst data
// to and from a local word buffer. A burst that reaches the last window word is
// disconnected. All state updates happen on the falling clock edge.
// Optional feature: define PCI_TGT_PARITY_EN to generate registered even parity
// on par. Without it, par is tied low.
//   clk    : bus clock, falling edge active
//   rst    : asynchronous reset, active high
//   frame  : active-low transaction framing from the initiator
//   irdy   : active-low initiator ready
//   ad_in  : address/data from the bus
//   cbe    : command during the address phase, active-low byte enables during data phases
//   trdy   : active-low target ready
//   devsel : active-low device select
//   stop   : active-low disconnect request
//   ad_out : read data driven onto the bus
//   ad_oe  : output enable for ad_out
//   par    : even parity over ad_out and cbe
//   state  : current FSM state, for debug
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for a falling frame that carries a hit address
// DECODE     | claimed; devsel asserted, read turnaround started
// WAIT       | initial trdy latency of WAIT_STATES cycles
// DATA       | trdy asserted; a data phase completes when irdy is also low
// DISCONNECT | window end reached; stop held until the initiator drops frame
// TURNAROUND | one-cycle release of devsel/trdy/stop/ad_oe
module pci_target_fsm
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          ADDR_W      = 3,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame,
    input  logic        irdy,
    input  logic [31:0] ad_in,
    input  logic [3:0]  cbe,
    output logic        trdy,
    output logic        devsel,
    output logic        stop,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        par,
    output logic [2:0]  state
);

    pci_state_t        st;
    logic              frame_q;
    logic              is_read;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        wait_cnt;
    logic [31:0]       rd_data;
    logic              hit;
    logic              cmd_ok;
    logic              xfer;

    assign hit     = (ad_in[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign cmd_ok  = (cbe == CMD_MEM_READ) || (cbe == CMD_MEM_WRITE);
    assign xfer    = (st == DATA) && !irdy && !trdy;
    assign ptr_inc = ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
    // Read data is registered, so on a completing phase the buffer is addressed
    // one word ahead. This makes the next word's data appear with the next phase.
    assign rd_addr = xfer ? ptr_inc : ptr;
    assign state   = st;

    pci_tgt_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we      (xfer && !is_read),
        .wr_addr (ptr),
        .wr_data (ad_in),
        .be_n    (cbe),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            frame_q  <= 1'b1;
            is_read  <= 1'b0;
            ptr      <= '0;
            wait_cnt <= '0;
            trdy     <= 1'b1;
            devsel   <= 1'b1;
            stop     <= 1'b1;
            ad_oe    <= 1'b0;
            ad_out   <= '0;
        end else begin
            frame_q <= frame;
            case (st)
                IDLE: begin
                    if (frame_q && !frame && hit && cmd_ok) begin
                        ptr     <= ad_in[ADDR_W+1:2];
                        is_read <= (cbe == CMD_MEM_READ);
                        devsel  <= 1'b0;
                        ad_oe   <= (cbe == CMD_MEM_READ);
                        st      <= DECODE;
                    end
                end
                DECODE: begin
                    if (frame && irdy) begin
                        // The initiator gave up before any data phase.
                        devsel <= 1'b1;
                        ad_oe  <= 1'b0;
                        st     <= TURNAROUND;
                    end else if (WAIT_STATES > 0) begin
                        wait_cnt <= 3'(WAIT_STATES);
                        st       <= WAIT;
                    end else begin
                        trdy <= 1'b0;
                        stop <= ~(&ptr);
                        if (is_read) ad_out <= rd_data;
                        st <= DATA;
                    end
                end
                WAIT: begin
                    if (frame && irdy) begin
                        devsel <= 1'b1;
                        ad_oe  <= 1'b0;
                        st     <= TURNAROUND;
                    end else if (wait_cnt == 3'd1) begin
                        wait_cnt <= '0;
                        trdy     <= 1'b0;
                        stop     <= ~(&ptr);
                        if (is_read) ad_out <= rd_data;
                        st <= DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        ptr <= ptr_inc;
                        if (frame) begin
                            trdy   <= 1'b1;
                            devsel <= 1'b1;
                            stop   <= 1'b1;
                            ad_oe  <= 1'b0;
                            st     <= TURNAROUND;
                        end else if (&ptr) begin
                            // The last window word is done and the initiator still
                            // wants more data, so hold stop until frame goes high.
                            trdy  <= 1'b1;
                            stop  <= 1'b0;
                            ad_oe <= 1'b0;
                            st    <= DISCONNECT;
                        end else begin
                            // Assert stop ahead of time for the last window word.
                            stop <= ~(&ptr_inc);
                            if (is_read) ad_out <= rd_data;
                        end
                    end
                end
                DISCONNECT: begin
                    if (frame) begin
                        devsel <= 1'b1;
                        stop   <= 1'b1;
                        st     <= TURNAROUND;
                    end
                end
                TURNAROUND: begin
                    trdy   <= 1'b1;
                    devsel <= 1'b1;
                    stop   <= 1'b1;
                    ad_oe  <= 1'b0;
                    st     <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef PCI_TGT_PARITY_EN
    logic par_q;

    // Parity for a read data-phase cycle is presented on the cycle after it.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (st == DATA && is_read) begin
            par_q <= ^{ad_out, cbe};
        end
    end

    assign par = par_q;
`else
    assign par = 1'b0;
`endif

endmodule

// File: tb/tb_pci_target_fsm.sv
module tb_pci_target_fsm;
    import pci_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame;
    logic        irdy;
    logic [31:0] ad_in;
    logic [3:0]  cbe;
    logic        trdy;
    logic        devsel;
    logic        stop;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic        par;
    logic [2:0]  state;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pci_target_fsm #(
        .BASE_ADDR   (32'h0000_1000),
        .ADDR_W      (3),
        .WAIT_STATES (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .frame  (frame),
        .irdy   (irdy),
        .ad_in  (ad_in),
        .cbe    (cbe),
        .trdy   (trdy),
        .devsel (devsel),
        .stop   (stop),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .par    (par),
        .state  (state)
    );

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, vectors=%0d", nvec);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_idle();
        frame = 1'b1; irdy = 1'b1; ad_in = '0; cbe = '0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
        frame = 1'b0; irdy = 1'b1; ad_in = a; cbe = cmd;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_idle();
        #1 rst = 1'b1;
        #2;
        nvec++; if (state !== 3'(IDLE)) begin nerr++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE); end
        nvec++; if (trdy !== 1'b1) begin nerr++; $display("FAIL reset_trdy got=%b exp=1", trdy); end
        nvec++; if (devsel !== 1'b1) begin nerr++; $display("FAIL reset_devsel got=%b exp=1", devsel); end
        nvec++; if (stop !== 1'b1) begin nerr++; $display("FAIL reset_stop got=%b exp=1", stop); end
        nvec++; if (ad_oe !== 1'b0) begin nerr++; $display("FAIL reset_ad_oe got=%b exp=0", ad_oe); end
        nvec++; if (ad_out !== 32'h0) begin nerr++; $display("FAIL reset_ad_out got=%h exp=0", ad_out); end
        nvec++; if (par !== 1'b0) begin nerr++; $display("FAIL reset_par got=%b exp=0", par); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic write_single(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr_phase(a, CMD_MEM_WRITE);
        nvec++; if (devsel !== 1'b0) begin nerr++; $display("FAIL wr_devsel a=%h got=%b exp=0", a, devsel); end
        nvec++; if (ad_oe !== 1'b0) begin nerr++; $display("FAIL wr_ad_oe a=%h got=%b exp=0", a, ad_oe); end
        frame = 1'b1; irdy = 1'b0; ad_in = d; cbe = be;
        step();
        nvec++; if (state !== 3'(WAIT) || trdy !== 1'b1) begin nerr++; $display("FAIL wr_wait a=%h state=%0d trdy=%b exp state=%0d trdy=1", a, state, trdy, WAIT); end
        step();
        nvec++; if (state !== 3'(DATA) || trdy !== 1'b0) begin nerr++; $display("FAIL wr_data a=%h state=%0d trdy=%b exp state=%0d trdy=0", a, state, trdy, DATA); end
        step();
        nvec++; if (state !== 3'(TURNAROUND) || devsel !== 1'b1 || trdy !== 1'b1) begin nerr++; $display("FAIL wr_turn a=%h state=%0d devsel=%b trdy=%b exp state=%0d 1 1", a, state, devsel, trdy, TURNAROUND); end
        bus_idle();
        step();
        nvec++; if (state !== 3'(IDLE)) begin nerr++; $display("FAIL wr_idle a=%h got=%0d exp=%0d", a, state, IDLE); end
    endtask

    task automatic read_single(input logic [31:0] a, input logic [31:0] exp);
        nvec++; if (ad_oe !== 1'b0) begin nerr++; $display("FAIL rd_pre_ad_oe a=%h got=%b exp=0", a, ad_oe); end
        addr_phase(a, CMD_MEM_READ);
        nvec++; if (devsel !== 1'b0 || ad_oe !== 1'b1 || trdy !== 1'b1) begin nerr++; $display("FAIL rd_decode a=%h devsel=%b ad_oe=%b trdy=%b exp 0 1 1", a, devsel, ad_oe, trdy); end
        frame = 1'b1; irdy = 1'b0; ad_in = '0; cbe = 4'b0000;
        step();
        nvec++; if (state !== 3'(WAIT) || trdy !== 1'b1 || ad_oe !== 1'b1) begin nerr++; $display("FAIL rd_wait a=%h state=%0d trdy=%b ad_oe=%b exp %0d 1 1", a, state, trdy, ad_oe, WAIT); end
        step();
        nvec++; if (trdy !== 1'b0 || ad_oe !== 1'b1) begin nerr++; $display("FAIL rd_data_ctl a=%h trdy=%b ad_oe=%b exp 0 1", a, trdy, ad_oe); end
        nvec++; if (ad_out !== exp) begin nerr++; $display("FAIL rd_data a=%h got=%h exp=%h", a, ad_out, exp); end
        step();
        nvec++; if (state !== 3'(TURNAROUND) || ad_oe !== 1'b0 || devsel !== 1'b1) begin nerr++; $display("FAIL rd_turn a=%h state=%0d ad_oe=%b devsel=%b exp %0d 0 1", a, state, ad_oe, devsel, TURNAROUND); end
        bus_idle();
        step();
        nvec++; if (state !== 3'(IDLE)) begin nerr++; $display("FAIL rd_idle a=%h got=%0d exp=%0d", a, state, IDLE); end
    endtask

    task automatic test_single_write_read();
        write_single(32'h0000_1004, 32'hDEADBEEF, 4'b0000);
        read_single(32'h0000_1004, 32'hDEADBEEF);
    endtask

    task automatic test_byte_enable();
        write_single(32'h0000_1008, 32'hFFFFFFFF, 4'b0000);
        write_single(32'h0000_1008, 32'h11223344, 4'b1100);
        read_single(32'h0000_1008, 32'hFFFF3344);
    endtask

    task automatic test_burst_write();
        addr_phase(32'h0000_1000, CMD_MEM_WRITE);
        frame = 1'b0; irdy = 1'b0; ad_in = 32'h1000_0000; cbe = 4'b0000;
        step();
        step();
        nvec++; if (state !== 3'(DATA) || trdy !== 1'b0) begin nerr++; $display("FAIL bw_enter state=%0d trdy=%b exp %0d 0", state, trdy, DATA); end
        step();
        ad_in = 32'h2111_1111;
        step();
        irdy = 1'b1; ad_in = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            step();
            nvec++; if (state !== 3'(DATA) || trdy !== 1'b0 || stop !== 1'b1) begin nerr++; $display("FAIL bw_stall%0d state=%0d trdy=%b stop=%b exp %0d 0 1", i, state, trdy, stop, DATA); end
        end
        irdy = 1'b0; ad_in = 32'h3222_2222;
        step();
        frame = 1'b1; ad_in = 32'h4333_3333;
        step();
        nvec++; if (state !== 3'(TURNAROUND) || devsel !== 1'b1 || trdy !== 1'b1) begin nerr++; $display("FAIL bw_turn state=%0d devsel=%b trdy=%b exp %0d 1 1", state, devsel, trdy, TURNAROUND); end
        bus_idle();
        step();
        nvec++; if (state !== 3'(IDLE)) begin nerr++; $display("FAIL bw_idle got=%0d exp=%0d", state, IDLE); end
        read_single(32'h0000_1000, 32'h1000_0000);
        read_single(32'h0000_1004, 32'h2111_1111);
        read_single(32'h0000_1008, 32'h3222_2222);
        read_single(32'h0000_100C, 32'h4333_3333);
    endtask

    task automatic test_miss();
        addr_phase(32'h0000_2000, CMD_MEM_READ);
        frame = 1'b0; irdy = 1'b0; ad_in = '0; cbe = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            nvec++; if (state !== 3'(IDLE) || devsel !== 1'b1 || trdy !== 1'b1 || ad_oe !== 1'b0) begin nerr++; $display("FAIL miss_addr%0d state=%0d devsel=%b trdy=%b ad_oe=%b exp 0 1 1 0", i, state, devsel, trdy, ad_oe); end
            step();
        end
        bus_idle();
        step();
        addr_phase(32'h0000_1000, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            nvec++; if (state !== 3'(IDLE) || devsel !== 1'b1) begin nerr++; $display("FAIL miss_cmd%0d state=%0d devsel=%b exp 0 1", i, state, devsel); end
            step();
        end
        bus_idle();
        step();
    endtask

    task automatic test_disconnect();
        write_single(32'h0000_1018, 32'hA5A5_6666, 4'b0000);
        write_single(32'h0000_101C, 32'h7777_C3C3, 4'b0000);
        addr_phase(32'h0000_1018, CMD_MEM_READ);
        frame = 1'b0; irdy = 1'b0; ad_in = '0; cbe = 4'b0000;
        step();
        step();
        nvec++; if (ad_out !== 32'hA5A5_6666 || trdy !== 1'b0 || stop !== 1'b1) begin nerr++; $display("FAIL dc_word6 ad_out=%h trdy=%b stop=%b exp a5a56666 0 1", ad_out, trdy, stop); end
        step();
        nvec++; if (ad_out !== 32'h7777_C3C3 || trdy !== 1'b0 || stop !== 1'b0) begin nerr++; $display("FAIL dc_word7 ad_out=%h trdy=%b stop=%b exp 7777c3c3 0 0", ad_out, trdy, stop); end
        step();
        nvec++; if (state !== 3'(DISCONNECT) || trdy !== 1'b1 || stop !== 1'b0 || devsel !== 1'b0) begin nerr++; $display("FAIL dc_enter state=%0d trdy=%b stop=%b devsel=%b exp %0d 1 0 0", state, trdy, stop, devsel, DISCONNECT); end
        step();
        nvec++; if (state !== 3'(DISCONNECT) || trdy !== 1'b1) begin nerr++; $display("FAIL dc_no_third state=%0d trdy=%b exp %0d 1", state, trdy, DISCONNECT); end
        frame = 1'b1; irdy = 1'b1;
        step();
        nvec++; if (state !== 3'(TURNAROUND) || devsel !== 1'b1 || stop !== 1'b1) begin nerr++; $display("FAIL dc_release state=%0d devsel=%b stop=%b exp %0d 1 1", state, devsel, stop, TURNAROUND); end
        bus_idle();
        step();
        nvec++; if (state !== 3'(IDLE)) begin nerr++; $display("FAIL dc_idle got=%0d exp=%0d", state, IDLE); end
    endtask

    task automatic test_reset_mid_burst();
        addr_phase(32'h0000_1010, CMD_MEM_WRITE);
        frame = 1'b0; irdy = 1'b0; ad_in = 32'h4444_4444; cbe = 4'b0000;
        step();
        step();
        step();
        nvec++; if (state !== 3'(DATA)) begin nerr++; $display("FAIL rb_in_data got=%0d exp=%0d", state, DATA); end
        ad_in = 32'h5555_5555;
        #2 rst = 1'b1;
        #1;
        nvec++; if (state !== 3'(IDLE) || trdy !== 1'b1 || devsel !== 1'b1 || stop !== 1'b1) begin nerr++; $display("FAIL rb_ctl state=%0d trdy=%b devsel=%b stop=%b exp 0 1 1 1", state, trdy, devsel, stop); end
        nvec++; if (ad_oe !== 1'b0 || ad_out !== 32'h0 || par !== 1'b0) begin nerr++; $display("FAIL rb_data ad_oe=%b ad_out=%h par=%b exp 0 0 0", ad_oe, ad_out, par); end
        step();
        rst = 1'b0;
        bus_idle();
        step();
        read_single(32'h0000_1010, 32'h4444_4444);
        read_single(32'h0000_1000, 32'h1000_0000);
        read_single(32'h0000_101C, 32'h7777_C3C3);
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_byte_enable();
        test_burst_write();
        test_miss();
        test_disconnect();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
